// File: rtl/ringmod_fx_controller.sv
// rtl/ringmod_fx_controller.sv - ring-modulator mode sequencer (optional feature: RINGMOD_CTRL_ZC_EN)
// Debounced button steps BYPASS/DALEK/ROBOT/BELL, applying changes at a PCM zero crossing.
module ringmod_fx_controller #(
    parameter int          DEBOUNCE_CYCLES = 48000,
    parameter logic [31:0] LIMIT_DALEK     = 32'd80000,
    parameter logic [31:0] LIMIT_ROBOT     = 32'd16000,
    parameter logic [31:0] LIMIT_BELL      = 32'd4800,
    parameter int          ZC_TIMEOUT      = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_next,
    input  logic        sample_valid,
    input  logic [15:0] pcm_in,
    output logic        fx_enable,
    output logic [31:0] toggle_limit,
    output logic [1:0]  mode,
    output logic        busy
);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ARMED, APPLY} state_t;

    logic [1:0]     sync_q;
    logic           db_level;
    logic [DBW-1:0] db_cnt;
    logic           press;
    state_t         state_q, state_d;
    logic [1:0]     target_q, target_d;
    logic           prev_sign_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= 2'b00;
            db_level <= 1'b0;
            db_cnt   <= '0;
        end else begin
            sync_q <= {sync_q[0], btn_next};
            if (sync_q[1] != db_level) begin
                if (db_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
                    db_level <= sync_q[1];
                    db_cnt   <= '0;
                end else begin
                    db_cnt <= db_cnt + DBW'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // Press fires in the same cycle the debounced level commits high.
    assign press = sync_q[1] & ~db_level & (db_cnt == DBW'(DEBOUNCE_CYCLES - 1));

`ifdef RINGMOD_CTRL_ZC_EN
    localparam int ZW = $clog2(ZC_TIMEOUT + 1);
    logic [ZW-1:0] zc_cnt_q, zc_cnt_d;
    logic          zc_hit;
    assign zc_hit = (pcm_in == 16'd0) || (pcm_in[15] != prev_sign_q);
`else
    localparam int unused_zc_timeout = ZC_TIMEOUT;
    logic unused_pcm;
    assign unused_pcm = ^pcm_in[14:0];
`endif

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
`ifdef RINGMOD_CTRL_ZC_EN
        zc_cnt_d = zc_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (press) begin
                    target_d = mode + 2'd1;
`ifdef RINGMOD_CTRL_ZC_EN
                    zc_cnt_d = '0;
`endif
                    state_d  = ARMED;
                end
            end
            ARMED: begin
                if (press)
                    target_d = target_q + 2'd1;
                if (sample_valid) begin
`ifdef RINGMOD_CTRL_ZC_EN
                    if (zc_hit || zc_cnt_q == ZW'(ZC_TIMEOUT - 1))
                        state_d = APPLY;
                    else
                        zc_cnt_d = zc_cnt_q + ZW'(1);
`else
                    state_d = APPLY;
`endif
                end
            end
            APPLY: begin
                if (press) begin
                    target_d = target_q + 2'd1;
`ifdef RINGMOD_CTRL_ZC_EN
                    zc_cnt_d = '0;
`endif
                    state_d  = ARMED;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            target_q <= 2'd0;
`ifdef RINGMOD_CTRL_ZC_EN
            zc_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
`ifdef RINGMOD_CTRL_ZC_EN
            zc_cnt_q <= zc_cnt_d;
`endif
        end
    end

    // BYPASS keeps the last carrier limit so re-enabling resumes cleanly.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode         <= 2'd0;
            fx_enable    <= 1'b0;
            toggle_limit <= LIMIT_DALEK;
            prev_sign_q  <= 1'b0;
        end else begin
            if (sample_valid)
                prev_sign_q <= pcm_in[15];
            if (state_q == APPLY) begin
                mode      <= target_q;
                fx_enable <= (target_q != 2'd0);
                case (target_q)
                    2'd1:    toggle_limit <= LIMIT_DALEK;
                    2'd2:    toggle_limit <= LIMIT_ROBOT;
                    2'd3:    toggle_limit <= LIMIT_BELL;
                    default: toggle_limit <= toggle_limit;
                endcase
            end
        end
    end

    assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_ringmod_fx_controller.sv
// tb/tb_ringmod_fx_controller.sv - directed-vector bench for ringmod_fx_controller
module tb_ringmod_fx_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_next = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] pcm_in = 16'd0;
    logic        fx_enable;
    logic [31:0] toggle_limit;
    logic [1:0]  mode;
    logic        busy;

    int n_checks = 0;
    int n_fail = 0;

    ringmod_fx_controller #(
        .DEBOUNCE_CYCLES(8),
        .ZC_TIMEOUT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_next(btn_next),
        .sample_valid(sample_valid),
        .pcm_in(pcm_in),
        .fx_enable(fx_enable),
        .toggle_limit(toggle_limit),
        .mode(mode),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          presses;
        logic [15:0] pcm;
        logic [1:0]  exp_mode;
        logic        exp_fx;
        logic [31:0] exp_limit;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic press();
        btn_next = 1'b1;
        repeat (20) @(negedge clk);
        btn_next = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    // Leaves the bench one posedge after the strobe was sampled.
    task automatic strobe(input logic [15:0] v);
        @(negedge clk);
        sample_valid = 1'b1;
        pcm_in = v;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1, -16'sd10,    2'd1, 1'b1, 32'd80000};
        vecs[1] = '{1, 16'sd0,      2'd2, 1'b1, 32'd16000};
        vecs[2] = '{1, -16'sd1,     2'd3, 1'b1, 32'd4800};
        vecs[3] = '{1, 16'sd5,      2'd0, 1'b0, 32'd4800};
        vecs[4] = '{2, -16'sd7,     2'd2, 1'b1, 32'd16000};
        vecs[5] = '{4, 16'sd3,      2'd2, 1'b1, 32'd16000};
        vecs[6] = '{3, -16'sd32768, 2'd1, 1'b1, 32'd80000};
        vecs[7] = '{2, 16'sd32767,  2'd3, 1'b1, 32'd4800};
        vecs[8] = '{1, -16'sd100,   2'd0, 1'b0, 32'd4800};

        repeat (3) @(negedge clk);
        check("reset_mode", 32'(mode), 32'd0);
        check("reset_fx", 32'(fx_enable), 32'd0);
        check("reset_limit", toggle_limit, 32'd80000);
        check("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            for (int p = 0; p < vecs[i].presses; p++) press();
            strobe(vecs[i].pcm);
            @(negedge clk);
            check($sformatf("vec%0d_mode", i), 32'(mode), 32'(vecs[i].exp_mode));
            check($sformatf("vec%0d_fx", i), 32'(fx_enable), 32'(vecs[i].exp_fx));
            check($sformatf("vec%0d_limit", i), toggle_limit, vecs[i].exp_limit);
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
            repeat (5) @(negedge clk);
        end

        // Short glitch never reaches the debounce threshold.
        btn_next = 1'b1;
        repeat (5) @(negedge clk);
        btn_next = 1'b0;
        repeat (20) @(negedge clk);
        check("glitch_busy", 32'(busy), 32'd0);

        strobe(-16'sd50);
        @(negedge clk);
        check("idle_strobe_mode", 32'(mode), 32'd0);
        check("idle_strobe_busy", 32'(busy), 32'd0);

        // Bounce then a solid press: exactly one step.
        btn_next = 1'b1;
        repeat (3) @(negedge clk);
        btn_next = 1'b0;
        repeat (3) @(negedge clk);
        press();
        check("bounce_busy", 32'(busy), 32'd1);
        strobe(16'sd100);
        check("latency_mode_apply", 32'(mode), 32'd0);
        check("latency_busy_apply", 32'(busy), 32'd1);
        @(negedge clk);
        check("bounce_mode", 32'(mode), 32'd1);
        check("bounce_fx", 32'(fx_enable), 32'd1);
        check("bounce_limit", toggle_limit, 32'd80000);
        check("bounce_busy_done", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);

        // No crossing: timeout path with zc, first strobe without.
        press();
`ifdef RINGMOD_CTRL_ZC_EN
        for (int s = 0; s < 3; s++) begin
            strobe(16'sd1000);
            repeat (8) @(negedge clk);
        end
        check("timeout_mode_wait", 32'(mode), 32'd1);
        check("timeout_busy_wait", 32'(busy), 32'd1);
`endif
        strobe(16'sd1000);
        @(negedge clk);
        check("timeout_mode", 32'(mode), 32'd2);
        check("timeout_limit", toggle_limit, 32'd16000);
        check("timeout_busy", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);

        // Wrap: from BELL, two presses land on DALEK.
        press();
        strobe(-16'sd5);
        @(negedge clk);
        check("wrap_pre_mode", 32'(mode), 32'd3);
        press();
        press();
        strobe(16'sd5);
        @(negedge clk);
        check("wrap_mode", 32'(mode), 32'd1);
        check("wrap_fx", 32'(fx_enable), 32'd1);
        check("wrap_limit", toggle_limit, 32'd80000);
        repeat (5) @(negedge clk);

        // Reset while ARMED discards the pending request.
        press();
        press();
        check("armed_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_fx", 32'(fx_enable), 32'd0);
        check("rst_limit", toggle_limit, 32'd80000);
        check("rst_busy", 32'(busy), 32'd0);
        strobe(-16'sd5);
        repeat (2) @(negedge clk);
        strobe(16'sd5);
        repeat (2) @(negedge clk);
        check("rst_after_mode", 32'(mode), 32'd0);
        check("rst_after_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
